// File: rtl/regfile_wport_arbiter_if.sv
// rtl/regfile_wport_arbiter_if.sv - write-port arbiter bus bundle
//
// Groups every signal of regfile_wport_arbiter except clk/rst.
//   WB side   : wb_wr, wb_rd[4:0], wb_data[31:0]
//   MDU side  : mdu_valid, mdu_ready, mdu_rd[4:0], mdu_data[31:0]
//   Decode    : id_rs1[4:0], id_rs2[4:0], id_hazard, pipe_stall
//   Bank port : wr, rd[4:0], rd_in[31:0]
// slave  : the arbiter's view
// master : the view of the environment that drives it
interface regfile_wport_arbiter_if;
  logic        wb_wr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_hazard;
  logic        pipe_stall;
  logic        wr;
  logic [4:0]  rd;
  logic [31:0] rd_in;

  modport slave (
    input  wb_wr, wb_rd, wb_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    input  id_rs1, id_rs2,
    output id_hazard, pipe_stall,
    output wr, rd, rd_in
  );

  modport master (
    output wb_wr, wb_rd, wb_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    output id_rs1, id_rs2,
    input  id_hazard, pipe_stall,
    input  wr, rd, rd_in
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - register bank write-port arbiter (WB vs MDU)
//
// WB writes always win the bank write port; MDU results queue in a small FIFO
// and drain in cycles where WB is not writing. A starvation FSM freezes the
// pipeline when the FIFO head has been blocked STARVE_LIMIT cycles in a row.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : WB request, MDU valid/ready handshake, decode sources and
//                  hazard/stall flags, bank write port (wr, rd, rd_in)
module regfile_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_wport_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [SW-1:0] starve;
  state_t        state;

  logic wb_hit;
  logic empty;
  logic full;
  logic accept;
  logic push;
  logic pop;

  function automatic logic src_match(input logic [4:0] r, input logic [4:0] s1,
                                     input logic [4:0] s2);
    return (r != 5'd0) && ((r == s1) || (r == s2));
  endfunction

  assign wb_hit = bus.wb_wr && (bus.wb_rd != 5'd0);
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  // Ready depends only on registered occupancy, so a same-cycle pop never
  // raises it.
  assign bus.mdu_ready = !full;
  assign accept        = bus.mdu_valid && !full;
  // r0 results complete the handshake but are dropped.
  assign push          = accept && (bus.mdu_rd != 5'd0);
  assign pop           = !rst && !wb_hit && !empty;
  assign count_next    = count + CW'(push) - CW'(pop);

  always_comb begin
    bus.wr    = 1'b0;
    bus.rd    = 5'd0;
    bus.rd_in = 32'd0;
    if (!rst) begin
      if (wb_hit) begin
        bus.wr    = 1'b1;
        bus.rd    = bus.wb_rd;
        bus.rd_in = bus.wb_data;
      end else if (!empty) begin
        bus.wr    = 1'b1;
        bus.rd    = mem_rd[rd_ptr];
        bus.rd_in = mem_data[rd_ptr];
      end
    end
  end

  // A head being written this cycle is already resolved for decode because
  // the bank writes at negedge and is read in the second half of the cycle.
  always_comb begin
    logic [AW-1:0] idx;
    logic          hz;
    idx = '0;
    hz  = accept && src_match(bus.mdu_rd, bus.id_rs1, bus.id_rs2);
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if ((CW'(k) < count) && !((k == 0) && pop)) begin
        if (src_match(mem_rd[idx], bus.id_rs1, bus.id_rs2)) hz = 1'b1;
      end
    end
    bus.id_hazard = hz;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= bus.mdu_rd;
      mem_data[wr_ptr] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      starve         <= '0;
      bus.pipe_stall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          starve <= '0;
          if (count_next != '0) state <= PEND;
        end
        PEND: begin
          if (pop) begin
            starve <= '0;
            state  <= (count_next == '0) ? IDLE : PEND;
          end else begin
            starve <= starve + SW'(1);
            if (starve + SW'(1) == SW'(STARVE_LIMIT)) begin
              state          <= FORCE;
              bus.pipe_stall <= 1'b1;
            end
          end
        end
        FORCE: begin
          // A WB write that ignores the stall still wins; keep forcing.
          if (pop) begin
            starve         <= '0;
            bus.pipe_stall <= 1'b0;
            state          <= (count_next == '0) ? IDLE : PEND;
          end
        end
        default: begin
          state          <= IDLE;
          starve         <= '0;
          bus.pipe_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_wport_arbiter.md
# regfile_wport_arbiter

Arbitrates the single write port of the pipelined register bank between the WB stage and the multi-cycle multiply/divide unit (MDU). WB writes always win. MDU results wait in a small FIFO and drain in cycles when WB is not writing. The block also tells decode when a source register still has a pending MDU result, and stalls the pipeline when MDU results have been starved too long.

## Interface
- DEPTH, 2: MDU result FIFO entries (power of two, 2..8).
- STARVE_LIMIT, 4: consecutive blocked cycles of a FIFO head before a forced drain (≥1).

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_wr  in  1  WB stage write request.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  FIFO can accept; a transfer occurs when mdu_valid & mdu_ready.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- id_rs1, id_rs2  in  5 each  decode-stage source registers.
- id_hazard  out  1  a decode source has a pending MDU write.
- pipe_stall  out  1  registered; pipeline freeze request.
- wr  out  1  register bank write enable.
- rd  out  5  register bank write address.
- rd_in  out  32  register bank write data.

## Operation
- **Write-port selection (combinational):**
  - wb_hit = wb_wr & (wb_rd≠0).
  - If wb_hit: wr=1, rd=wb_rd, rd_in=wb_data.
  - Else if the FIFO is non-empty: write the head entry and pop it at posedge.
  - Else wr=0, and rd/rd_in are don't-care (drive 0).
  - wr=0 whenever rst=1.
  - A WB write to r0 never reaches the bank, and a FIFO head may use that cycle.
- **MDU acceptance:**
  - mdu_ready = !full, computed from registered occupancy only. A pop in the same cycle does not raise mdu_ready.
  - An accepted entry with mdu_rd=0 completes the handshake but is discarded, not enqueued.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - FIFO order is strict; there is no bypass. An accepted result is written no earlier than the next cycle.
- **id_hazard:** 1 if any nonzero id_rs1/id_rs2 matches:
  - a valid FIFO entry other than the head being written this cycle (the bank writes at negedge and reads in the second half, so that head is resolved); or
  - an incoming accepted mdu_rd this cycle.
  - Register 0 never hazards.
- **Starvation FSM (states IDLE, PEND, FORCE; counter `starve` of width clog2(STARVE_LIMIT+1)):**
  - IDLE: FIFO empty; starve=0.
    - Go to PEND when occupancy becomes nonzero.
  - PEND: head present.
    - Head written this cycle: starve←0. Go to IDLE if the FIFO becomes empty, else stay in PEND.
    - Head blocked by wb_hit: starve←starve+1. When the new starve equals STARVE_LIMIT, go to FORCE.
  - FORCE: pipe_stall=1.
    - The pipeline guarantees wb_wr=0 while pipe_stall=1, so the head drains.
    - If wb_wr=1 anyway, WB still wins (no data loss) and the block stays in FORCE.
    - On the head write: starve←0, pipe_stall←0 at the same posedge, then go to PEND or IDLE by occupancy.
- pipe_stall is a flop: 1 exactly while the state is FORCE.

## Timing
- **Reset values** (held while rst=1, state cleared asynchronously):
  - FIFO empty, state IDLE, starve=0.
  - mdu_ready=1, pipe_stall=0, wr=0, id_hazard=0 (unless an MDU input is offered).
- **Reset mid-operation:** pending FIFO contents are discarded, and the MDU must re-issue them.
- **Latency:**
  - MDU accept to bank write: 1 cycle minimum when WB is idle.
  - Worst case: DEPTH·(STARVE_LIMIT+1) cycles under continuous WB traffic.
- **Full FIFO:** mdu_ready=0 until the posedge after a pop.
- **Outputs:**
  - wr/rd/rd_in/id_hazard/mdu_ready are valid before negedge of clk. The bank latches at negedge.
  - pipe_stall changes only at posedge or on rst.

## Test plan
- **Reset:** assert rst mid-run with 2 entries queued → wr=0, mdu_ready=1, pipe_stall=0. After release, no queued write ever appears.
- **Idle drain:** MDU pushes r5=0xDEADBEEF with wb_wr=0 → the next cycle has wr=1, rd=5, rd_in=0xDEADBEEF. id_hazard=1 for id_rs1=5 in the push cycle only.
- **WB priority and full FIFO:** wb_wr=1 to r7 every cycle while the MDU pushes r8 then r9 → both queue, mdu_ready=0 on the third cycle, and every write goes to r7.
- **Starvation:** continuous wb_wr=1 with 1 entry (r10), STARVE_LIMIT=4 → pipe_stall=1 after 4 blocked cycles. When wb_wr drops to 0: r10 is written, and pipe_stall=0 at the following posedge.
- **r0 handling:** wb_wr=1 with wb_rd=0 while the head is r3=0x1 → r3 is written. MDU push to r0 → handshake completes, FIFO occupancy unchanged, no write.
- **Simultaneous push/pop:** 1 entry present (r4), WB idle, MDU pushes r6 → r4 written, occupancy stays 1, r6 written the next cycle. id_hazard for rs1=4 is 0 in the pop cycle.
